ysyx_041461_axi_rd_arbiter: RTL and testbench

- Shares the single AXI4 read channel (AR/R) of the core's memory master port between NUM_MASTERS internal requesters, for example the LSU/DCache refill and the IFU/ICache refill.
- Sits inside the core, ahead of the io_master_ar*/r* ports that feed the AXI crossbar.
- Allows one outstanding burst at a time. The grant is held from AR issue until the R beat carrying rlast completes.

---
 rtl/ysyx_041461_axi_rd_arbiter_pkg.sv | 31 +++
 rtl/ysyx_041461_arb_pick.sv | 40 ++++
 rtl/ysyx_041461_axi_rd_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ysyx_041461_axi_rd_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_041461_axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI4 read-channel arbiter: AXI encodings,
// the arbiter state type and a small index-width helper.
package ysyx_041461_axi_rd_arbiter_pkg;

  // Width of the downstream AXI id field.
  localparam int ID_W = 4;

  // AXI burst type encodings.
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // AXI response encodings.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Arbiter phases: waiting for requests, issuing AR, streaming R beats.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  // Bits needed to hold a requester index (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ysyx_041461_arb_pick.sv
// Combinational winner selection: scans the request vector starting at
// ptr and wrapping around, returning the first set requester as both a
// one-hot vector and an index. With ptr tied to zero it is a plain
// lowest-index-wins priority picker.
module ysyx_041461_arb_pick #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] grant_oh,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   valid
);

  logic [NUM_MASTERS-1:0] req_rot;

  // (base + off) mod NUM_MASTERS for off in 0..NUM_MASTERS-1.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
    return IDX_W'(sum);
  endfunction

  // Rotate requests so bit k is requester (ptr+k); the lowest set bit wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    grant_idx = '0;
    req_rot   = NUM_MASTERS'({req, req} >> ptr);
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (req_rot[k]) grant_idx = wrap_add(ptr, k);
    end
  end

  assign valid    = |req;
  assign grant_oh = valid ? (NUM_MASTERS'(1) << grant_idx) : '0;

endmodule

// File: rtl/ysyx_041461_axi_rd_arbiter.sv
// Shares one AXI4 read channel (AR/R) between NUM_MASTERS requesters with a
// single outstanding burst. The grant is taken in IDLE, the AR fields are
// captured so the downstream address phase stays stable, and the grant is
// held until the rlast beat handshakes. One IDLE bubble separates bursts.
// Optional feature macro: YSYX_041461_ARB_RR_EN selects round-robin
// arbitration; without it the lowest requesting index wins.
module ysyx_041461_axi_rd_arbiter
  import ysyx_041461_axi_rd_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int ID_BASE     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  // requester side
  input  logic [NUM_MASTERS-1:0]        m_arvalid,
  output logic [NUM_MASTERS-1:0]        m_arready,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr,
  input  logic [NUM_MASTERS*8-1:0]      m_arlen,
  input  logic [NUM_MASTERS*3-1:0]      m_arsize,
  input  logic [NUM_MASTERS*2-1:0]      m_arburst,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  input  logic [NUM_MASTERS-1:0]        m_rready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [1:0]                    m_rresp,
  output logic                          m_rlast,
  // downstream side
  output logic                          s_arvalid,
  input  logic                          s_arready,
  output logic [ID_W-1:0]               s_arid,
  output logic [ADDR_W-1:0]             s_araddr,
  output logic [7:0]                    s_arlen,
  output logic [2:0]                    s_arsize,
  output logic [1:0]                    s_arburst,
  input  logic                          s_rvalid,
  output logic                          s_rready,
  input  logic [ID_W-1:0]               s_rid,
  input  logic [1:0]                    s_rresp,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_rlast
);

  localparam int IDX_W = idx_width(NUM_MASTERS);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       grant_q;
  logic [NUM_MASTERS-1:0] grant_oh;
  logic [ADDR_W-1:0]      araddr_q;
  logic [7:0]             arlen_q;
  logic [2:0]             arsize_q;
  logic [1:0]             arburst_q;

  logic [NUM_MASTERS-1:0] pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_ptr;

  logic [ADDR_W-1:0]      sel_addr;
  logic [7:0]             sel_len;
  logic [2:0]             sel_size;
  logic [1:0]             sel_burst;

  logic                   load_ar;
  logic                   granted_rready;

  // Only one burst is ever in flight, so the returned id carries no routing information.
  logic                   unused_rid;
  assign unused_rid = ^s_rid;

`ifdef YSYX_041461_ARB_RR_EN
  logic [IDX_W-1:0] ptr_q;

  // Round-robin pointer: moves just past the winner on each AR handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (state_q == ADDR && s_arready) begin
      ptr_q <= (grant_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  assign pick_ptr = ptr_q;
`else
  assign pick_ptr = '0;
`endif

  ysyx_041461_arb_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_pick (
    .req       (m_arvalid),
    .ptr       (pick_ptr),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .valid     (pick_valid)
  );

  // Select the winning requester's AR fields from the packed buses.
  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_oh[i]) begin
        sel_addr  = m_araddr[i*ADDR_W +: ADDR_W];
        sel_len   = m_arlen[i*8 +: 8];
        sel_size  = m_arsize[i*3 +: 3];
        sel_burst = m_arburst[i*2 +: 2];
      end
    end
  end

  assign grant_oh       = NUM_MASTERS'(1) << grant_q;
  assign granted_rready = |(m_rready & grant_oh);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample their inputs from the same clock edge.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake outputs for the granted requester.
  always_comb begin
    state_d   = state_q;
    load_ar   = 1'b0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          load_ar = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        s_arvalid = 1'b1;
        if (s_arready) begin
          m_arready = grant_oh;
          state_d   = DATA;
        end
      end
      DATA: begin
        m_rvalid = s_rvalid ? grant_oh : '0;
        s_rready = granted_rready;
        if (s_rvalid && granted_rready && s_rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture grant and AR fields when a winner is chosen.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the captured AR fields are reset too, so s_ar* reads as zero
    // straight out of reset rather than showing stale or unknown values.
    if (rst) begin
      grant_q   <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else if (load_ar) begin
      grant_q   <= pick_idx;
      araddr_q  <= sel_addr;
      arlen_q   <= sel_len;
      arsize_q  <= sel_size;
      arburst_q <= sel_burst;
    end
  end

  assign s_arid    = ID_W'(ID_BASE + int'(grant_q));
  assign s_araddr  = araddr_q;
  assign s_arlen   = arlen_q;
  assign s_arsize  = arsize_q;
  assign s_arburst = arburst_q;

  // Read data, response and last are broadcast to every requester.
  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast;

endmodule

// File: tb/tb_ysyx_041461_axi_rd_arbiter.sv
// Self-checking bench for ysyx_041461_axi_rd_arbiter: directed and random
// bursts compared against a transaction-level model of the arbitration
// rules. Honours YSYX_041461_ARB_RR_EN for the expected grant order.
module tb_ysyx_041461_axi_rd_arbiter;
  import ysyx_041461_axi_rd_arbiter_pkg::*;

  localparam int N   = 2;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IDB = 0;

  logic            clk, rst;
  logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N*AW-1:0] m_araddr;
  logic [N*8-1:0]  m_arlen;
  logic [N*3-1:0]  m_arsize;
  logic [N*2-1:0]  m_arburst;
  logic [DW-1:0]   m_rdata, s_rdata;
  logic [1:0]      m_rresp, s_rresp, s_arburst;
  logic            m_rlast, s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [3:0]      s_arid, s_rid;
  logic [AW-1:0]   s_araddr;
  logic [7:0]      s_arlen;
  logic [2:0]      s_arsize;

  ysyx_041461_axi_rd_arbiter #(
    .NUM_MASTERS (N), .ADDR_W (AW), .DATA_W (DW), .ID_BASE (IDB)
  ) dut (
    .clk (clk), .rst (rst),
    .m_arvalid (m_arvalid), .m_arready (m_arready), .m_araddr (m_araddr),
    .m_arlen (m_arlen), .m_arsize (m_arsize), .m_arburst (m_arburst),
    .m_rvalid (m_rvalid), .m_rready (m_rready), .m_rdata (m_rdata),
    .m_rresp (m_rresp), .m_rlast (m_rlast),
    .s_arvalid (s_arvalid), .s_arready (s_arready), .s_arid (s_arid),
    .s_araddr (s_araddr), .s_arlen (s_arlen), .s_arsize (s_arsize),
    .s_arburst (s_arburst), .s_rvalid (s_rvalid), .s_rready (s_rready),
    .s_rid (s_rid), .s_rresp (s_rresp), .s_rdata (s_rdata), .s_rlast (s_rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Requester model: pending requests and their AR fields, plus the
  // round-robin pointer as the arbitration rules define it.
  logic [N-1:0] pend;
  logic [31:0]  maddr  [N];
  logic [7:0]   mlen   [N];
  logic [2:0]   msize  [N];
  logic [1:0]   mburst [N];
  int           rr_ptr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic new_req(input int i);
    pend[i]   = 1'b1;
    maddr[i]  = $urandom;
    mlen[i]   = 8'($urandom_range(0, 7));
    msize[i]  = 3'($urandom_range(0, 3));
    mburst[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : BURST_INCR;
  endtask

  task automatic apply_ar();
    for (int i = 0; i < N; i++) begin
      m_arvalid[i]        = pend[i];
      m_araddr[i*AW +: AW] = pend[i] ? maddr[i]  : $urandom;
      m_arlen[i*8 +: 8]    = pend[i] ? mlen[i]   : 8'($urandom);
      m_arsize[i*3 +: 3]   = pend[i] ? msize[i]  : 3'($urandom);
      m_arburst[i*2 +: 2]  = pend[i] ? mburst[i] : 2'($urandom);
    end
  endtask

  // First pending requester in search order starting at ptr.
  function automatic int model_pick(input logic [N-1:0] p, input int ptr);
    for (int off = 0; off < N; off++) begin
      if (p[(ptr + off) % N]) return (ptr + off) % N;
    end
    return -1;
  endfunction

  // One complete burst, starting in an IDLE cycle at the drive point.
  task automatic serve_one(input int stall, input int hold_beat, input bit rearm, input bit add_others);
    int g, b, guard, ptr;
    bit held;
    logic [7:0] len;
    apply_ar();
    mid();
    check("idle_s_arvalid", s_arvalid, 0);
    check("idle_s_rready", s_rready, 0);
    check("idle_m_arready", m_arready, 0);
    check("idle_m_rvalid", m_rvalid, 0);
`ifdef YSYX_041461_ARB_RR_EN
    ptr = rr_ptr;
`else
    ptr = 0;
`endif
    g = model_pick(pend, ptr);
    if (g < 0) begin
      $display("FAIL bench_no_request: observed=none expected=pending");
      $fatal(1, "no pending request");
    end
    len = mlen[g];
    for (int k = 0; k < stall; k++) begin
      tick();
      s_arready = 1'b0;
      mid();
      check("stall_s_arvalid", s_arvalid, 1);
      check("stall_s_araddr", s_araddr, maddr[g]);
      check("stall_m_arready", m_arready, 0);
    end
    tick();
    s_arready = 1'b1;
    mid();
    check("ar_m_arready", m_arready, 64'(1) << g);
    check("ar_s_arvalid", s_arvalid, 1);
    check("ar_s_araddr", s_araddr, maddr[g]);
    check("ar_s_arlen", s_arlen, mlen[g]);
    check("ar_s_arsize", s_arsize, msize[g]);
    check("ar_s_arburst", s_arburst, mburst[g]);
    check("ar_s_arid", s_arid, 4'(IDB + g));
    tick();
    s_arready = 1'b0;
    pend[g] = 1'b0;
    if (rearm) new_req(g);
    if (add_others) begin
      for (int i = 0; i < N; i++) if (i != g && !pend[i] && $urandom_range(0, 1) == 1) new_req(i);
    end
`ifdef YSYX_041461_ARB_RR_EN
    rr_ptr = (g + 1) % N;
`endif
    apply_ar();
    b = 0;
    guard = 0;
    held = 1'b0;
    while (b <= int'(len) && guard < 100) begin
      s_rvalid = ($urandom_range(0, 3) != 0);
      s_rdata  = {$urandom, $urandom};
      s_rresp  = (b == 1) ? RESP_SLVERR : 2'($urandom_range(0, 3));
      s_rlast  = (b == int'(len));
      s_rid    = 4'($urandom);
      m_rready = N'($urandom);
      if (b == hold_beat && !held && s_rvalid) begin
        m_rready[g] = 1'b0;
        held = 1'b1;
      end else begin
        m_rready[g] = ($urandom_range(0, 4) != 0);
      end
      mid();
      check("r_m_rvalid", m_rvalid, s_rvalid ? (64'(1) << g) : 64'(0));
      check("r_s_rready", s_rready, m_rready[g]);
      check("r_m_rdata", m_rdata, s_rdata);
      check("r_m_rresp", m_rresp, s_rresp);
      check("r_m_rlast", m_rlast, s_rlast);
      check("r_s_arvalid", s_arvalid, 0);
      if (s_rvalid && m_rready[g]) b++;
      tick();
      guard++;
    end
    check("burst_done", b > int'(len), 1);
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    m_arvalid = '1; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    m_rready = '0; s_arready = 1'b1; s_rvalid = 1'b0; s_rid = '0;
    s_rresp = RESP_OKAY; s_rdata = '0; s_rlast = 1'b0;
    pend = '0; rr_ptr = 0;
    for (int i = 0; i < N; i++) begin
      maddr[i] = '0; mlen[i] = '0; msize[i] = '0; mburst[i] = '0;
    end

    // Reset state with requests asserted.
    repeat (2) @(posedge clk);
    mid();
    check("rst_s_arvalid", s_arvalid, 0);
    check("rst_s_rready", s_rready, 0);
    check("rst_m_arready", m_arready, 0);
    check("rst_m_rvalid", m_rvalid, 0);
    check("rst_s_araddr", s_araddr, 0);
    check("rst_s_arlen", s_arlen, 0);
    check("rst_s_arid", s_arid, 4'(IDB));
    tick();
    m_arvalid = '0;
    s_arready = 1'b0;
    rst = 1'b0;

    // Single request from master 0.
    new_req(0);
    maddr[0] = 32'h8000_0000; mlen[0] = 8'd3; msize[0] = 3'd3; mburst[0] = BURST_INCR;
    serve_one(0, -1, 1'b0, 1'b0);

    // Simultaneous requests, both held until served.
    new_req(0);
    new_req(1);
    serve_one(0, -1, 1'b0, 1'b0);
    serve_one(0, -1, 1'b0, 1'b0);

    // AR backpressure for five cycles and R backpressure on beat 2.
    new_req(1);
    mlen[1] = 8'd4;
    serve_one(5, 2, 1'b0, 1'b0);

    // Random traffic.
    for (int t = 0; t < 20; t++) begin
      if (pend == '0 || $urandom_range(0, 2) == 0) new_req($urandom_range(0, N - 1));
      serve_one($urandom_range(0, 3), $urandom_range(0, 4) - 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    while (pend != '0) serve_one(0, -1, 1'b0, 1'b0);

    // Reset in the middle of an arlen=7 burst.
    new_req(0);
    mlen[0] = 8'd7;
    apply_ar();
    mid();
    tick();
    s_arready = 1'b1;
    mid();
    check("rstmid_m_arready", m_arready, 1);
    tick();
    s_arready = 1'b0;
    pend[0] = 1'b0;
    apply_ar();
    for (int b = 0; b < 2; b++) begin
      s_rvalid = 1'b1; s_rlast = 1'b0; s_rdata = {$urandom, $urandom}; m_rready = '1;
      mid();
      check("rstmid_beat_m_rvalid", m_rvalid, 1);
      tick();
    end
    s_rvalid = 1'b1; s_rdata = {$urandom, $urandom};
    mid();
    check("rstmid_beat2_m_rvalid", m_rvalid, 1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_async_m_rvalid", m_rvalid, 0);
    check("rstmid_async_s_rready", s_rready, 0);
    check("rstmid_async_s_arvalid", s_arvalid, 0);
    check("rstmid_async_m_arready", m_arready, 0);
    tick();
    rst = 1'b0;
    rr_ptr = 0;
    pend = '0;
    mid();
    check("rstmid_after_m_rvalid", m_rvalid, 0);
    check("rstmid_after_s_rready", s_rready, 0);
    check("rstmid_after_s_arvalid", s_arvalid, 0);
    tick();
    s_rvalid = 1'b0;
    new_req(1);
    serve_one(0, -1, 1'b0, 1'b0);

    // Three back-to-back rounds with both requesters continuously requesting.
    new_req(0);
    new_req(1);
    for (int r = 0; r < 3; r++) serve_one(0, -1, 1'b1, 1'b0);
    while (pend != '0) serve_one(0, -1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
